// File: rtl/mux_temporal_sel.sv
// Temporal-select multiplexer: decodes a time-coded select (arrival time or pulse
// width within a gamma cycle) into an input index and captures that word.
// Optional macro MUX_HOLD_LAST_EN keeps y/sel_idx from the last valid capture.
module mux_temporal_sel #(
  parameter int NUM_INPUTS        = 16,
  parameter int BUS_WIDTH         = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int MODE              = 0
) (
  input  logic                            aclk,
  input  logic                            grst,
  input  logic                            gamma_start,
  input  logic [NUM_INPUTS*BUS_WIDTH-1:0] inputs,
  input  logic                            select_line,
  output logic [BUS_WIDTH-1:0]            y,
  output logic                            y_valid,
  output logic [$clog2(NUM_INPUTS)-1:0]   sel_idx,
  output logic                            no_select,
  output logic                            sel_overflow
);
  localparam int CW = $clog2(GAMMA_CYCLE_WIDTH) + 1;
  localparam int IW = $clog2(NUM_INPUTS);
  localparam logic [CW-1:0] T_LAST = CW'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            t_q, t_d, w_q, w_d, t_inc, w_inc;
  logic [BUS_WIDTH-1:0]     y_q, y_d;
  logic [IW-1:0]            sel_idx_q, sel_idx_d;
  logic                     y_valid_q, y_valid_d;
  logic                     no_select_q, no_select_d;
  logic                     sel_overflow_q, sel_overflow_d;
  logic                     cap;
  logic [CW-1:0]            cap_k;
  logic [31:0]              cap_k32;
  logic [NUM_INPUTS-1:0][BUS_WIDTH-1:0] words;

  assign words   = inputs;
  assign t_inc   = (t_q == '1) ? t_q : t_q + CW'(1);
  assign w_inc   = (w_q == '1) ? w_q : w_q + CW'(1);
  assign cap_k32 = 32'(cap_k);

  always_comb begin
    state_d        = state_q;
    t_d            = t_q;
    w_d            = w_q;
    y_d            = y_q;
    sel_idx_d      = sel_idx_q;
    y_valid_d      = y_valid_q;
    no_select_d    = no_select_q;
    sel_overflow_d = sel_overflow_q;
    cap            = 1'b0;
    cap_k          = '0;
    if (gamma_start) begin
      state_d        = S_WAIT;
      t_d            = '0;
      w_d            = '0;
      y_valid_d      = 1'b0;
      no_select_d    = 1'b0;
      sel_overflow_d = 1'b0;
`ifndef MUX_HOLD_LAST_EN
      y_d            = '0;
      sel_idx_d      = '0;
`endif
    end else begin
      case (state_q)
        S_WAIT: begin
          if (select_line) begin
            if (MODE == 0) begin
              cap   = 1'b1;
              cap_k = t_q;
            end else begin
              w_d     = CW'(1);
              t_d     = t_inc;
              state_d = S_PULSE;
            end
          end else if (t_q >= T_LAST) begin
            no_select_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            t_d = t_inc;
          end
        end
        S_PULSE: begin
          t_d = t_inc;
          if (!select_line) begin
            cap   = 1'b1;
            cap_k = w_q - CW'(1);
          end else if (t_q >= T_LAST) begin
            // pulse still high at frame end: truncated width is the index
            cap   = 1'b1;
            cap_k = w_q;
          end else begin
            w_d = w_inc;
          end
        end
        default: ;
      endcase
      if (cap) begin
        state_d = S_DONE;
        if (cap_k32 < 32'(NUM_INPUTS)) begin
          y_d       = words[cap_k32[IW-1:0]];
          sel_idx_d = cap_k32[IW-1:0];
          y_valid_d = 1'b1;
        end else begin
          sel_overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_q        <= S_IDLE;
      t_q            <= '0;
      w_q            <= '0;
      y_q            <= '0;
      sel_idx_q      <= '0;
      y_valid_q      <= 1'b0;
      no_select_q    <= 1'b0;
      sel_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_q            <= t_d;
      w_q            <= w_d;
      y_q            <= y_d;
      sel_idx_q      <= sel_idx_d;
      y_valid_q      <= y_valid_d;
      no_select_q    <= no_select_d;
      sel_overflow_q <= sel_overflow_d;
    end
  end

  assign y            = y_q;
  assign y_valid      = y_valid_q;
  assign sel_idx      = sel_idx_q;
  assign no_select    = no_select_q;
  assign sel_overflow = sel_overflow_q;
endmodule

// File: tb/tb_mux_temporal_sel.sv
// Scoreboard bench: three DUTs (MODE0/G16, MODE1/G16, MODE0/G32) share one
// stimulus stream; a frame-level model predicts each outcome at issue time.
module tb_mux_temporal_sel;
  localparam int N  = 16;
  localparam int BW = 8;
  localparam int L  = 36;

  typedef struct packed {
    logic [BW-1:0] y;
    logic [3:0]    idx;
    logic          v;
    logic          ns;
    logic          ov;
  } exp_t;

  logic              aclk = 1'b0;
  logic              grst = 1'b0;
  logic              gamma_start = 1'b0;
  logic              select_line = 1'b0;
  logic [N*BW-1:0]   inputs = '0;
  logic [2:0][BW-1:0] y;
  logic [2:0][3:0]   sidx;
  logic [2:0]        yv, ns, ov;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq [3][$];
  logic            sel_a [L];
  logic [N*BW-1:0] wd_a  [L];
`ifdef MUX_HOLD_LAST_EN
  logic [BW-1:0] hy   [3];
  logic [3:0]    hidx [3];
`endif

  always #5 aclk = ~aclk;

  mux_temporal_sel #(.NUM_INPUTS(N), .BUS_WIDTH(BW), .GAMMA_CYCLE_WIDTH(16), .MODE(0)) u_a (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .inputs(inputs), .select_line(select_line),
    .y(y[0]), .y_valid(yv[0]), .sel_idx(sidx[0]), .no_select(ns[0]), .sel_overflow(ov[0]));
  mux_temporal_sel #(.NUM_INPUTS(N), .BUS_WIDTH(BW), .GAMMA_CYCLE_WIDTH(16), .MODE(1)) u_b (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .inputs(inputs), .select_line(select_line),
    .y(y[1]), .y_valid(yv[1]), .sel_idx(sidx[1]), .no_select(ns[1]), .sel_overflow(ov[1]));
  mux_temporal_sel #(.NUM_INPUTS(N), .BUS_WIDTH(BW), .GAMMA_CYCLE_WIDTH(32), .MODE(0)) u_c (
    .aclk(aclk), .grst(grst), .gamma_start(gamma_start), .inputs(inputs), .select_line(select_line),
    .y(y[2]), .y_valid(yv[2]), .sel_idx(sidx[2]), .no_select(ns[2]), .sel_overflow(ov[2]));

  function automatic exp_t got_of(input int d);
    return {y[d], sidx[d], yv[d], ns[d], ov[d]};
  endfunction

  task automatic chk(input string nm, input int d, input exp_t g, input exp_t e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s dut%0d: got y=%h idx=%0d v=%b ns=%b ov=%b, expected y=%h idx=%0d v=%b ns=%b ov=%b",
               nm, d, g.y, g.idx, g.v, g.ns, g.ov, e.y, e.idx, e.v, e.ns, e.ov);
    end
  endtask

  // Frame-level model: edge k is the k-th clock edge after the gamma_start edge.
  function automatic void predict(input int d, output exp_t e, output int ecap);
    int g   = (d == 2) ? 32 : 16;
    int idx = 0;
    int r   = -1;
    e    = '0;
    ecap = -1;
    if (d != 1) begin
      for (int k = 0; k < g; k++) if (sel_a[k]) begin ecap = k; idx = k; break; end
    end else begin
      for (int k = 0; k < g; k++) if (sel_a[k]) begin r = k; break; end
      if (r >= 0)
        for (int k = r + 1; k < L; k++) begin
          if (!sel_a[k]) begin idx = k - r - 1; ecap = k; break; end
          if (k >= g - 1) begin idx = k - r; ecap = k; break; end
        end
    end
    if (ecap < 0) begin
      e.ns = 1'b1;
      ecap = g - 1;
    end else if (idx < N) begin
      e.v   = 1'b1;
      e.idx = 4'(idx);
      e.y   = wd_a[ecap][idx*BW +: BW];
    end else begin
      e.ov = 1'b1;
    end
  endfunction

  task automatic clr_hold();
`ifdef MUX_HOLD_LAST_EN
    for (int d = 0; d < 3; d++) begin hy[d] = '0; hidx[d] = '0; end
`endif
  endtask

  function automatic logic [N*BW-1:0] rnd_words();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic fill_const();
    logic [N*BW-1:0] w;
    for (int i = 0; i < N; i++) w[i*BW +: BW] = 8'h10 + 8'(i);
    for (int k = 0; k < L; k++) begin wd_a[k] = w; sel_a[k] = 1'b0; end
  endtask

  task automatic run_frame(input int len, input logic gs_sel);
    exp_t e;
    int   ec;
    for (int d = 0; d < 3; d++) begin
      predict(d, e, ec);
      if (ec < len) begin
`ifdef MUX_HOLD_LAST_EN
        if (e.v) begin hy[d] = e.y; hidx[d] = e.idx; end
        else begin e.y = hy[d]; e.idx = hidx[d]; end
`endif
        sbq[d].push_back(e);
      end
    end
    gamma_start = 1'b1;
    select_line = gs_sel;
    inputs      = rnd_words();
    @(posedge aclk); #1;
    gamma_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      select_line = sel_a[k];
      inputs      = wd_a[k];
      @(posedge aclk); #1;
    end
    select_line = 1'b0;
  endtask

  for (genvar d = 0; d < 3; d++) begin : g_mon
    logic prev_any = 1'b0;
    exp_t cur      = '0;
    always @(negedge aclk) begin
      automatic exp_t e   = cur;
      automatic logic any = yv[d] | ns[d] | ov[d];
      if (any) begin
        if (!prev_any) begin
          if (sbq[d].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_outcome dut%0d: outcome flags raised with no frame expected", d);
          end else begin
            e = sbq[d].pop_front();
          end
        end
        chk("outcome", d, got_of(d), e);
      end
      cur      <= e;
      prev_any <= any;
    end
  end

  initial begin
    #1 grst = 1'b1;
    clr_hold();
    #5;
    for (int d = 0; d < 3; d++) chk("reset_state", d, got_of(d), '0);
    @(posedge aclk); #1 grst = 1'b0;
    // select activity in IDLE must produce nothing
    repeat (6) begin select_line = 1'b1; @(posedge aclk); #1; end
    select_line = 1'b0;

    fill_const(); sel_a[5] = 1'b1;                        run_frame(L, 1'b0);
    fill_const();                                         run_frame(L, 1'b0);
    fill_const(); sel_a[0] = 1'b1;                        run_frame(L, 1'b1);
    fill_const(); for (int k = 2; k < 5; k++) sel_a[k] = 1'b1; run_frame(L, 1'b0);
    fill_const(); for (int k = 11; k < L; k++) sel_a[k] = 1'b1; run_frame(L, 1'b0);
    fill_const(); sel_a[20] = 1'b1;                       run_frame(L, 1'b0);
    // gamma_start mid-WAIT restarts the timer; aborted partial frame yields nothing
    fill_const();                                         run_frame(7, 1'b0);
    fill_const(); sel_a[5] = 1'b1;                        run_frame(L, 1'b0);

    // async reset while results are held
    #2 grst = 1'b1;
    #1 for (int d = 0; d < 3; d++) chk("async_reset_done", d, got_of(d), '0);
    clr_hold();
    @(posedge aclk); #1 grst = 1'b0;

    // reset mid-PULSE (dut1); dut0/dut2 already captured index 3
    fill_const(); for (int k = 3; k < L; k++) sel_a[k] = 1'b1; run_frame(6, 1'b0);
    select_line = 1'b1;
    #2 grst = 1'b1;
    #1 for (int d = 0; d < 3; d++) chk("async_reset_pulse", d, got_of(d), '0);
    clr_hold();
    @(posedge aclk); #1 grst = 1'b0;
    repeat (20) begin select_line = 1'($urandom); @(posedge aclk); #1; end
    select_line = 1'b0;

    for (int f = 0; f < 60; f++) begin
      int r   = int'($urandom_range(0, 35));
      int len = int'($urandom_range(1, 20));
      logic noisy = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < L; k++) begin
        wd_a[k]  = rnd_words();
        sel_a[k] = (k >= r && k < r + len) || (noisy && k >= r + len && $urandom_range(0, 1) == 1);
      end
      run_frame(L, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      #1;
    end

    repeat (4) @(posedge aclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (sbq[d].size() != 0) begin
        n_fail++;
        $display("FAIL missing_outcome dut%0d: %0d expected outcomes never seen, required 0", d, sbq[d].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_temporal_sel.md
Name: mux_temporal_sel

Overview:
- Parametrised temporal-select multiplexer for the TNN datapath.
- Decodes a time-coded select (spike arrival time or pulse width, relative to the gamma-cycle start) into an input index, and captures the selected BUS_WIDTH word.
- Framed explicitly per gamma cycle.
- Reports the selected index, no-event and out-of-range conditions to downstream column logic.

Parameters:
- NUM_INPUTS, 16: number of selectable input words, ≥2.
- BUS_WIDTH, 8: width of each input word and of y.
- GAMMA_CYCLE_WIDTH, 16: aclk cycles per gamma cycle; ≥NUM_INPUTS is legal, smaller is legal (upper indices unreachable).
- MODE, 0: select encoding; 0 = rising-edge arrival time, 1 = pulse width.

Ports:
- aclk, input, 1: clock; all state updates on posedge.
- grst, input, 1: reset, asynchronous, active-high.
- gamma_start, input, 1: single-cycle pulse opening a gamma cycle.
- inputs, input, NUM_INPUTS*BUS_WIDTH: packed words; word i at bits [i*BUS_WIDTH +: BUS_WIDTH].
- select_line, input, 1: time-coded select, synchronous to aclk.
- y, output, BUS_WIDTH: captured word.
- y_valid, output, 1: level; high from capture until next gamma_start/reset.
- sel_idx, output, $clog2(NUM_INPUTS): decoded index at capture.
- no_select, output, 1: level; gamma cycle expired with no event.
- sel_overflow, output, 1: level; decoded index ≥ NUM_INPUTS.

Behaviour:
- Reset (grst high, async): state IDLE; y, y_valid, sel_idx, no_select, sel_overflow, t, w all 0.
- Counters: t (gamma timer) and w (pulse width), each $clog2(GAMMA_CYCLE_WIDTH)+1 bits, saturating; never wrap.
- States: IDLE, WAIT, PULSE (MODE 1 only), DONE.
- gamma_start sampled high, any state:
  - next state WAIT; t=0; w=0.
  - y_valid, no_select, sel_overflow, sel_idx, y cleared.
  - Highest priority; aborts any in-progress capture.
  - select_line on that same edge is ignored.
- IDLE/DONE without gamma_start: hold all outputs.
- MODE 0, WAIT, each edge:
  - select_line=1: capture index=t.
  - Otherwise, if t==GAMMA_CYCLE_WIDTH-1: no_select=1, go DONE.
  - Otherwise t<=t+1.
  - select_line high on the first edge after gamma_start gives index 0.
- MODE 1, WAIT, each edge:
  - select_line=1: w<=1, go PULSE.
  - Otherwise same timeout rule as MODE 0.
  - t increments every edge in WAIT and PULSE.
- MODE 1, PULSE, each edge:
  - select_line=0: capture index=w-1.
  - Else if t==GAMMA_CYCLE_WIDTH-1: capture index=w (pulse truncated at frame end).
  - Else w<=w+1.
- Capture, index k, single edge:
  - k<NUM_INPUTS: y<=word k sampled on that edge; sel_idx<=k; y_valid<=1.
  - k≥NUM_INPUTS: sel_overflow<=1; y stays 0; sel_idx stays 0; y_valid stays 0.
  - Next state DONE either way.
- Latency: y/y_valid visible the cycle after the capturing edge.
- inputs are sampled only at capture; later changes do not affect y.
- At most one capture per gamma cycle; select_line activity in DONE is ignored.
- Outputs are mutually exclusive: exactly one of y_valid, no_select, sel_overflow is set in DONE; none in IDLE/WAIT/PULSE.
- grst mid-frame: immediate return to IDLE with all outputs 0; the next frame requires gamma_start.

Optional Feature:
- Macro: MUX_HOLD_LAST_EN.
- Defined: y and sel_idx are not cleared by gamma_start, and are not cleared on a no_select or overflow outcome. They retain the last valid capture until the next valid capture or grst. y_valid/no_select/sel_overflow behave unchanged.
- Undefined: behaviour exactly as above (cleared at gamma_start).

Test Plan:
- MODE 0, inputs[i]=8'h10+i, gamma_start, select_line high 5 edges later (t=5) -> next cycle y=8'h15, sel_idx=5, y_valid=1, no_select=0; stays until next gamma_start.
- MODE 0, select_line high together with gamma_start and on the following edge -> index 0, y=8'h10.
- MODE 0, no select for 16 edges -> no_select=1 after edge t=15, y_valid=0, y=0.
- MODE 1, pulse of 3 cycles starting t=2 -> capture at falling edge, sel_idx=2, y=8'h12. Pulse still high at t=15 from w=4 -> sel_idx=4.
- GAMMA_CYCLE_WIDTH=32, NUM_INPUTS=16, MODE 0, select at t=20 -> sel_overflow=1, y_valid=0. gamma_start during WAIT at t=7 -> t restarts, earlier frame yields no capture.
- grst asserted mid-PULSE -> all outputs 0 asynchronously. With MUX_HOLD_LAST_EN: y=8'h15 survives a subsequent gamma_start and a no_select frame.
